// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the reset sequencer and its environment.
interface rst_sequencer_if;
    logic       dcm_locked_i;
    logic       btn_i;
    logic       clr_i;
    logic       rst_bus_o;
    logic       rst_core_o;
    logic       ready_o;
    logic       lock_lost_o;
    logic [7:0] lock_loss_cnt_o;

    // Environment side: drives lock/button/clear, observes resets and status
    modport master (
        output dcm_locked_i, btn_i, clr_i,
        input  rst_bus_o, rst_core_o, ready_o, lock_lost_o, lock_loss_cnt_o
    );

    // Sequencer side
    modport slave (
        input  dcm_locked_i, btn_i, clr_i,
        output rst_bus_o, rst_core_o, ready_o, lock_lost_o, lock_loss_cnt_o
    );
endinterface

// File: rtl/rst_sequencer.sv
// Bus-domain reset sequencer: waits for DCM lock, holds, releases bus reset,
// then core reset; aborts on lock loss or debounced button press.
module rst_sequencer #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned CORE_DELAY      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    rst_sequencer_if.slave  bus
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > CORE_DELAY) ? HOLD_CYCLES : CORE_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, BUS_UP, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       lock_sync, btn_sync;
    logic [DB_W-1:0]  db_cnt;
    logic             locked_s, btn_s, press, abort;

    logic             rst_bus_c, rst_core_c, ready_c, lost_c;
    logic [7:0]       loss_cnt_c;
    logic             rst_bus_q, rst_core_q, ready_q, lost_q;
    logic [7:0]       loss_cnt_q;

    assign locked_s = lock_sync[1];
    assign btn_s    = btn_sync[1];
    assign press    = btn_s && (db_cnt >= DB_LAST);
    assign abort    = !locked_s || press;

    // Two-flop synchronizers for the asynchronous lock and button inputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_sync <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[0], bus.dcm_locked_i};
            btn_sync  <= {btn_sync[0], bus.btn_i};
        end
    end

    // Button debounce: count consecutive high cycles, saturate at the threshold
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            db_cnt <= '0;
        end else if (!btn_s) begin
            db_cnt <= '0;
        end else if (db_cnt != DB_LAST) begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // State and phase counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and phase counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (locked_s && !press) state_nxt = HOLD;
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = BUS_UP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            BUS_UP: begin
                if (abort) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == CORE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (abort) state_nxt = WAIT_LOCK;
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from next state; lock-loss stats with clear-then-count ordering
    always_comb begin
        rst_bus_c  = 1'b1;
        rst_core_c = 1'b1;
        ready_c    = 1'b0;
        lost_c     = bus.clr_i ? 1'b0 : lost_q;
        loss_cnt_c = bus.clr_i ? 8'd0 : loss_cnt_q;
        case (state_nxt)
            BUS_UP: rst_bus_c = 1'b0;
            RUN: begin
                rst_bus_c  = 1'b0;
                rst_core_c = 1'b0;
                ready_c    = 1'b1;
            end
            default: ;
        endcase
        if ((state == RUN) && !locked_s) begin
            lost_c = 1'b1;
            if (loss_cnt_c != 8'hFF) loss_cnt_c = loss_cnt_c + 8'd1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_bus_q  <= 1'b1;
            rst_core_q <= 1'b1;
            ready_q    <= 1'b0;
            lost_q     <= 1'b0;
            loss_cnt_q <= 8'd0;
        end else begin
            rst_bus_q  <= rst_bus_c;
            rst_core_q <= rst_core_c;
            ready_q    <= ready_c;
            lost_q     <= lost_c;
            loss_cnt_q <= loss_cnt_c;
        end
    end

    assign bus.rst_bus_o       = rst_bus_q;
    assign bus.rst_core_o      = rst_core_q;
    assign bus.ready_o         = ready_q;
    assign bus.lock_lost_o     = lost_q;
    assign bus.lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with a cycle-stamped expectation queue.
module tb_rst_sequencer;

    localparam int unsigned HOLD = 16;
    localparam int unsigned CORE = 4;
    localparam int unsigned DB   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    rst_sequencer_if dif ();

    rst_sequencer #(
        .HOLD_CYCLES     (HOLD),
        .CORE_DELAY      (CORE),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   exp_cnt = 0;

    // {rst_bus, rst_core, ready, lock_lost, lock_loss_cnt}
    function automatic logic [11:0] pk(logic b, logic c, logic r, logic l, logic [7:0] n);
        return {b, c, r, l, n};
    endfunction

    function automatic logic [11:0] obs();
        return {dif.rst_bus_o, dif.rst_core_o, dif.ready_o, dif.lock_lost_o, dif.lock_loss_cnt_o};
    endfunction

    task automatic expect_at(int c, logic [11:0] v, string tag);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check(string tag, logic [11:0] o, logic [11:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Advance n clock edges; sample 1ns after each edge and retire due expectations
    task automatic run(int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            checks++;
            assert (!(dif.rst_bus_o === 1'b1 && dif.rst_core_o === 1'b0)) else begin
                errors++;
                $error("FAIL order cyc=%0d observed bus=%b core=%b expected core=1 while bus=1",
                       cyc, dif.rst_bus_o, dif.rst_core_o);
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check(e.tag, obs(), e.v);
            end
        end
    endtask

    initial begin
        dif.dcm_locked_i = 1'b0;
        dif.btn_i        = 1'b0;
        dif.clr_i        = 1'b0;

        // Power-up reset and start sequence
        #2 rst_n = 1'b0;
        #1 check("reset_async", obs(), pk(1, 1, 0, 0, 8'd0));
        expect_at(3, pk(1, 1, 0, 0, 8'd0), "reset_hold");
        run(3);
        rst_n = 1'b1;
        run(6);
        dif.dcm_locked_i = 1'b1;
        expect_at(11, pk(1, 1, 0, 0, 8'd0), "lock_sync");
        expect_at(27, pk(1, 1, 0, 0, 8'd0), "hold_end");
        expect_at(28, pk(0, 1, 0, 0, 8'd0), "bus_release");
        expect_at(31, pk(0, 1, 0, 0, 8'd0), "core_delay");
        expect_at(32, pk(0, 0, 1, 0, 8'd0), "run");
        run(25);

        // Lock loss in RUN, then re-lock
        expect_at(36, pk(0, 0, 1, 0, 8'd0), "loss_pending");
        expect_at(37, pk(1, 1, 0, 1, 8'd1), "loss_abort");
        dif.dcm_locked_i = 1'b0;
        run(3);
        dif.dcm_locked_i = 1'b1;
        expect_at(55, pk(1, 1, 0, 1, 8'd1), "relock_hold");
        expect_at(56, pk(0, 1, 0, 1, 8'd1), "relock_bus");
        expect_at(59, pk(0, 1, 0, 1, 8'd1), "relock_delay");
        expect_at(60, pk(0, 0, 1, 1, 8'd1), "relock_run");
        run(24);

        // Bouncy button: two 5-cycle pulses must not reset
        expect_at(70, pk(0, 0, 1, 1, 8'd1), "bounce_mid");
        expect_at(75, pk(0, 0, 1, 1, 8'd1), "bounce_end");
        dif.btn_i = 1'b1; run(5);
        dif.btn_i = 1'b0; run(1);
        dif.btn_i = 1'b1; run(5);
        dif.btn_i = 1'b0; run(3);

        // Held button: reset 8 cycles after synchronized rise, held, then full sequence
        expect_at(84,  pk(0, 0, 1, 1, 8'd1), "press_pending");
        expect_at(85,  pk(1, 1, 0, 1, 8'd1), "press_abort");
        expect_at(87,  pk(1, 1, 0, 1, 8'd1), "press_held");
        expect_at(103, pk(1, 1, 0, 1, 8'd1), "press_hold_end");
        expect_at(104, pk(0, 1, 0, 1, 8'd1), "press_bus");
        expect_at(107, pk(0, 1, 0, 1, 8'd1), "press_delay");
        expect_at(108, pk(0, 0, 1, 1, 8'd1), "press_run");
        dif.btn_i = 1'b1; run(10);
        dif.btn_i = 1'b0; run(24);

        // Abort in HOLD at cnt=7, then abort in BUS_UP
        expect_at(111, pk(0, 0, 1, 1, 8'd1), "loss2_pending");
        expect_at(112, pk(1, 1, 0, 1, 8'd2), "loss2_abort");
        dif.dcm_locked_i = 1'b0; run(3);
        dif.dcm_locked_i = 1'b1; run(9);
        expect_at(124, pk(1, 1, 0, 1, 8'd2), "hold_abort");
        dif.dcm_locked_i = 1'b0; run(3);
        expect_at(131, pk(1, 1, 0, 1, 8'd2), "hold_restart");
        expect_at(142, pk(1, 1, 0, 1, 8'd2), "hold2_end");
        expect_at(143, pk(0, 1, 0, 1, 8'd2), "bus_up2");
        expect_at(146, pk(0, 1, 0, 1, 8'd2), "bus_abort_pending");
        expect_at(147, pk(1, 1, 0, 1, 8'd2), "bus_abort");
        expect_at(148, pk(1, 1, 0, 1, 8'd2), "bus_abort_held");
        dif.dcm_locked_i = 1'b1; run(20);
        dif.dcm_locked_i = 1'b0; run(4);

        // Repeated lock losses in RUN: counter saturates at 255
        exp_cnt = 2;
        for (int k = 0; k < 260; k++) begin
            expect_at(cyc + 23, pk(0, 0, 1, 1, 8'(exp_cnt)), "sat_run");
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            expect_at(cyc + 26, pk(1, 1, 0, 1, 8'(exp_cnt)), "sat_loss");
            dif.dcm_locked_i = 1'b1; run(23);
            dif.dcm_locked_i = 1'b0; run(3);
        end
        check("sat_255", obs(), pk(1, 1, 0, 1, 8'd255));

        // Clear pulse
        dif.clr_i = 1'b1; run(1);
        dif.clr_i = 1'b0;
        check("clr", obs(), pk(1, 1, 0, 0, 8'd0));

        // Clear coinciding with a counted loss, prior count 0 then prior count 1
        for (int k = 0; k < 2; k++) begin
            dif.dcm_locked_i = 1'b1; run(23);
            check("coin_run", obs(), pk(0, 0, 1, k[0], 8'(k)));
            dif.dcm_locked_i = 1'b0; run(2);
            dif.clr_i = 1'b1; run(1);
            dif.clr_i = 1'b0;
            check("clr_coincide", obs(), pk(1, 1, 0, 1, 8'd1));
        end

        // Asynchronous reset in the middle of BUS_UP
        dif.dcm_locked_i = 1'b1; run(20);
        check("bus_up_pre", obs(), pk(0, 1, 0, 1, 8'd1));
        #2 rst_n = 1'b0;
        #1 check("async_rst_mid", obs(), pk(1, 1, 0, 0, 8'd0));
        expect_at(cyc + 2, pk(1, 1, 0, 0, 8'd0), "async_rst_held");
        run(2);
        rst_n = 1'b1;
        run(3);

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=none expected=%h", sb[0].tag, sb[0].v);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Reset sequencer in the bus clock domain, driven by the DCM bus-clock output.
- Holds the bus and core resets asserted until the DCM reports lock, holds them for a programmable time, then releases the bus reset and, after a further delay, the core reset.
- Debounces the board reset button.
- Re-asserts both resets immediately if DCM lock is lost, and counts lock-loss events for debug.

Parameters:
- HOLD_CYCLES, 16: cycles both resets stay asserted after stable lock (>=1).
- CORE_DELAY, 4: cycles between bus-reset release and core-reset release. Must be even (core clock = bus clock / 2) and >=2.
- DEBOUNCE_CYCLES, 1024: consecutive synchronized-high cycles of btn_i that count as a press (>=2).

Ports:
- clk_i, input, 1: bus clock (DCM CLKFX after BUFG).
- rst_n_i, input, 1: asynchronous active-low reset; forces every register to its reset value.
- dcm_locked_i, input, 1: DCM LOCKED. Asynchronous to clk_i.
- btn_i, input, 1: board reset button, active-high. Asynchronous and bouncy.
- clr_i, input, 1: synchronous pulse; clears lock_lost_o and lock_loss_cnt_o.
- rst_bus_o, output, 1: active-high bus/peripheral reset. Registered.
- rst_core_o, output, 1: active-high core reset. Registered.
- ready_o, output, 1: high only in RUN.
- lock_lost_o, output, 1: sticky flag set when lock drops while in RUN.
- lock_loss_cnt_o, output, 8: saturating count of lock drops in RUN.

Behaviour:
- Reset values (rst_n_i=0): rst_bus_o=1, rst_core_o=1, ready_o=0, lock_lost_o=0, lock_loss_cnt_o=0, state=WAIT_LOCK, counters=0, synchronizers=0.
- Synchronization: dcm_locked_i and btn_i each pass through a 2-FF synchronizer. locked_s and btn_s reflect an input sampled at edge N from edge N+1.
- Debounce:
  - Counter increments while btn_s=1 and clears when btn_s=0.
  - press=1 while counter >= DEBOUNCE_CYCLES-1 and btn_s=1.
  - Counter saturates; it does not wrap.
- States, outputs registered and decoded from next-state:
  - WAIT_LOCK: rst_bus_o=1, rst_core_o=1, ready_o=0. Go to HOLD when locked_s=1 and press=0; cnt cleared.
  - HOLD: both resets asserted. cnt increments each cycle. When cnt=HOLD_CYCLES-1, go to BUS_UP and clear cnt. HOLD lasts exactly HOLD_CYCLES cycles.
  - BUS_UP: rst_bus_o=0, rst_core_o=1. After exactly CORE_DELAY cycles, go to RUN.
  - RUN: rst_bus_o=0, rst_core_o=0, ready_o=1.
- Abort: in HOLD, BUS_UP or RUN, locked_s=0 or press=1 forces WAIT_LOCK on the next edge, with both resets asserted on that edge.
- Lock loss in RUN: when locked_s=0, set lock_lost_o and increment lock_loss_cnt_o, saturating at 255.
  - A press alone does not count.
  - Lock loss in HOLD or BUS_UP does not count.
- Simultaneous events:
  - Lock loss and press together in RUN count as a lock loss.
  - clr_i in the same cycle as a counted lock loss: the set/increment wins, giving lock_lost_o=1 and cnt=1 when the prior count was 0. In that case the clear is applied first, then the increment.
- Ordering guarantee: rst_core_o is never 0 while rst_bus_o is 1.
- Latency:
  - Start: dcm_locked_i sampled 1 at edge N gives HOLD at N+2, rst_bus_o=0 at N+2+HOLD_CYCLES, and rst_core_o=0 plus ready_o=1 at N+2+HOLD_CYCLES+CORE_DELAY.
  - Abort: lock dropping at edge M asserts both resets at edge M+2.
- rst_n_i asserted mid-sequence returns to reset values asynchronously. Lock-loss statistics are also cleared.

Test Plan:
- Power-up: rst_n_i low 3 cycles, then high. Raise dcm_locked_i sampled at edge 10 with defaults. Expect rst_bus_o falls at edge 28, rst_core_o and ready_o at edge 32, with both 1 before.
- Lock loss in RUN: drop dcm_locked_i sampled at edge M. Expect both resets =1 at M+2, lock_lost_o=1, lock_loss_cnt_o=1. Re-lock and expect the full sequence again.
- Debounce: DEBOUNCE_CYCLES=8. Toggle btn_i high 5 cycles, low 1, high 5: expect no reset. Hold high 10 cycles: expect resets asserted 8 cycles after the synchronized rise, and held until release, then the full HOLD sequence. lock_loss_cnt_o unchanged.
- Abort in HOLD and BUS_UP: drop lock at HOLD cnt=7. Expect return to WAIT_LOCK, rst_core_o never 0, counter not incremented. Repeat during BUS_UP: rst_bus_o returns to 1, lock_loss_cnt_o unchanged.
- Saturation and clear: force 260 lock losses in RUN and expect lock_loss_cnt_o=255. Pulse clr_i and expect 0 and lock_lost_o=0. Pulse clr_i coinciding with a counted loss and expect cnt=1, flag=1.
- Async reset mid-BUS_UP: assert rst_n_i between edges. Expect all outputs at reset values immediately, without waiting for a clock edge.
